// File: rtl/router_pkg.sv
// router_pkg: shared constants and flit type for the router ingress path.
//   NUM_PORTS     - number of router destinations
//   ADDR_W        - destination address width
//   DATA_SIZE     - default flit payload width
//   router_flit_t - packed {addr, data} flit
package router_pkg;

    parameter int DATA_SIZE = 32;
    localparam int NUM_PORTS = 4;
    localparam int ADDR_W = 2;

    typedef struct packed {
        logic [ADDR_W-1:0]    addr;
        logic [DATA_SIZE-1:0] data;
    } router_flit_t;

endpackage

// File: rtl/router_sync_fifo.sv
// router_sync_fifo: generic DEPTH x WIDTH synchronous FIFO.
//   clk, resetn    - clock, synchronous active-low reset
//   push, wdata    - write request and data (ignored when full)
//   pop            - read request (ignored when empty)
//   rdata          - current head entry (combinational)
//   full, empty    - occupancy flags
//   level          - occupancy 0..DEPTH
module router_sync_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LVL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];

    // Storage carries no reset; pointers and level define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of 2, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/router_ingress_fifo.sv
// router_ingress_fifo: ingress buffer in front of the 4-way simple_router.
// Optional feature macro: ROUTER_STATS_EN (per-destination issue counters).
//   clk, resetn          - clock, synchronous active-low reset
//   in_valid/in_ready    - upstream handshake; in_addr/in_data flit fields
//   out_hold             - downstream pause, blocks issue on the next edge
//   din_en/addr/din      - registered one-cycle issue to the router
//   level                - FIFO occupancy 0..DEPTH
//   stat_cnt0..3         - saturating issue counts per destination (macro only)
//
// Handshake: a flit transfers at a rising edge where in_valid && in_ready.
// in_ready depends only on the FIFO level, never on in_valid or out_hold;
// upstream must keep the flit stable while in_valid && !in_ready.
module router_ingress_fifo
    import router_pkg::*;
#(
    parameter int DATA_SIZE = 32,
    parameter int DEPTH     = 4
`ifdef ROUTER_STATS_EN
    ,
    parameter int STAT_W    = 16
`endif
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ADDR_W-1:0]          in_addr,
    input  logic [DATA_SIZE-1:0]       in_data,
    input  logic                       out_hold,
    output logic                       din_en,
    output logic [ADDR_W-1:0]          addr,
    output logic [DATA_SIZE-1:0]       din,
    output logic [$clog2(DEPTH+1)-1:0] level
`ifdef ROUTER_STATS_EN
    ,
    output logic [STAT_W-1:0]          stat_cnt0,
    output logic [STAT_W-1:0]          stat_cnt1,
    output logic [STAT_W-1:0]          stat_cnt2,
    output logic [STAT_W-1:0]          stat_cnt3
`endif
);

    localparam int FLIT_W = ADDR_W + DATA_SIZE;

    logic              push;
    logic              pop;
    logic              full;
    logic              empty;
    logic [FLIT_W-1:0] head;

    // No bypass: a full FIFO refuses a flit even on a popping edge.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;
    assign pop      = !empty && !out_hold;

    router_sync_fifo #(
        .WIDTH (FLIT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .wdata  ({in_addr, in_data}),
        .pop    (pop),
        .rdata  (head),
        .full   (full),
        .empty  (empty),
        .level  (level)
    );

    // Idle cycles drive zero so the combinational router outputs stay zero.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            din_en <= 1'b0;
            addr   <= '0;
            din    <= '0;
        end else if (pop) begin
            din_en <= 1'b1;
            addr   <= head[DATA_SIZE +: ADDR_W];
            din    <= head[DATA_SIZE-1:0];
        end else begin
            din_en <= 1'b0;
            addr   <= '0;
            din    <= '0;
        end
    end

`ifdef ROUTER_STATS_EN
    logic [STAT_W-1:0] cnt [NUM_PORTS];

    // Counts follow the registered issue, so they lag din_en by one edge.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (din_en && (addr == ADDR_W'(i)) && (cnt[i] != '1)) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    assign stat_cnt0 = cnt[0];
    assign stat_cnt1 = cnt[1];
    assign stat_cnt2 = cnt[2];
    assign stat_cnt3 = cnt[3];
`endif

endmodule

// File: tb/tb_router_ingress_fifo.sv
module tb_router_ingress_fifo;

  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int LW = $clog2(DEPTH+1);

  logic          clk;
  logic          resetn;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_addr;
  logic [DW-1:0] in_data;
  logic          out_hold;
  logic          din_en;
  logic [1:0]    addr;
  logic [DW-1:0] din;
  logic [LW-1:0] level;
`ifdef ROUTER_STATS_EN
  logic [1:0]    stat_cnt0;
  logic [1:0]    stat_cnt1;
  logic [1:0]    stat_cnt2;
  logic [1:0]    stat_cnt3;
`endif

  int vec_cnt = 0;
  int miss_cnt = 0;
  logic [DW+1:0] exp_q[$];

  router_ingress_fifo #(
    .DATA_SIZE (DW),
    .DEPTH     (DEPTH)
`ifdef ROUTER_STATS_EN
    ,
    .STAT_W    (2)
`endif
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_data   (in_data),
    .out_hold  (out_hold),
    .din_en    (din_en),
    .addr      (addr),
    .din       (din),
    .level     (level)
`ifdef ROUTER_STATS_EN
    ,
    .stat_cnt0 (stat_cnt0),
    .stat_cnt1 (stat_cnt1),
    .stat_cnt2 (stat_cnt2),
    .stat_cnt3 (stat_cnt3)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      miss_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    repeat (cycles) step();
    exp_q.delete();
    resetn = 1'b1;
  endtask

  // driver: present a flit and hold it until the DUT accepts it
  task automatic push_flit(input logic [1:0] a, input logic [DW-1:0] d);
    int n;
    logic acc;
    n = 0;
    in_valid = 1'b1;
    in_addr = a;
    in_data = d;
    do begin
      @(negedge clk);
      acc = in_ready;
      step();
      n++;
    end while (!acc && n < 200);
    if (!acc) check("push_timeout", 64'd0, 64'd1);
    else exp_q.push_back({a, d});
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || level != 0) && n < 200) begin
      step();
      n++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (resetn) begin
      if (din_en) begin
        if (exp_q.size() == 0) begin
          check("unexpected_issue", {30'd0, addr, din}, 64'd0);
        end else begin
          check("issue_flit", {30'd0, addr, din}, {30'd0, exp_q.pop_front()});
        end
      end else begin
        check("idle_zero", {30'd0, addr, din}, 64'd0);
      end
    end
  end

  initial begin
    resetn = 1'b0;
    in_valid = 1'b0;
    in_addr = '0;
    in_data = '0;
    out_hold = 1'b0;

    // 1. reset state
    do_reset(2);
    check("rst_din_en", 64'(din_en), 64'd0);
    check("rst_addr", 64'(addr), 64'd0);
    check("rst_din", 64'(din), 64'd0);
    check("rst_level", 64'(level), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);

    // 2. single flit latency
    push_flit(2'd2, 32'hDEADBEEF);
    check("t2_no_same_edge", 64'(din_en), 64'd0);
    check("t2_level1", 64'(level), 64'd1);
    step();
    check("t2_din_en", 64'(din_en), 64'd1);
    check("t2_addr", 64'(addr), 64'd2);
    check("t2_din", 64'(din), 64'hDEADBEEF);
    step();
    check("t2_din_en_low", 64'(din_en), 64'd0);
    check("t2_out_zero", {30'd0, addr, din}, 64'd0);
    check("t2_level0", 64'(level), 64'd0);

    // 3. fill to full under hold
    out_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_flit(2'(i), 32'h10 + 32'(i));
    check("t3_level_full", 64'(level), 64'd4);
    check("t3_ready_low", 64'(in_ready), 64'd0);
    in_valid = 1'b1;
    in_addr = 2'd0;
    in_data = 32'h14;
    step();
    check("t3_5th_held", 64'(level), 64'd4);
    check("t3_hold_idle", 64'(din_en), 64'd0);
    out_hold = 1'b0;
    fork
      push_flit(2'd0, 32'h14);
      begin
        for (int i = 0; i < 5; i++) begin
          step();
          check("t3_consec_en", 64'(din_en), 64'd1);
        end
        step();
        check("t3_en_done", 64'(din_en), 64'd0);
      end
    join
    wait_drain();

    // 4. simultaneous push/pop across pointer wrap
    out_hold = 1'b1;
    push_flit(2'd1, 32'hA0);
    push_flit(2'd2, 32'hA1);
    check("t4_level2", 64'(level), 64'd2);
    out_hold = 1'b0;
    for (int i = 0; i < 12; i++) begin
      push_flit(2'(i + 3), 32'hB0 + 32'(i));
      check("t4_level_steady", 64'(level), 64'd2);
    end
    wait_drain();

    // 5. reset mid-traffic
    out_hold = 1'b1;
    for (int i = 0; i < 4; i++) push_flit(2'(3 - i), 32'hC0 + 32'(i));
    out_hold = 1'b0;
    step();
    check("t5_level3", 64'(level), 64'd3);
    check("t5_din_en", 64'(din_en), 64'd1);
    @(negedge clk);
    resetn = 1'b0;
    in_valid = 1'b1;
    in_addr = 2'd1;
    in_data = 32'hBAD;
    step();
    exp_q.delete();
    check("t5_rst_din_en", 64'(din_en), 64'd0);
    check("t5_rst_level", 64'(level), 64'd0);
    check("t5_rst_ready", 64'(in_ready), 64'd1);
    resetn = 1'b1;
    in_valid = 1'b0;
    repeat (6) step();
    check("t5_no_stale", 64'(level), 64'd0);

`ifdef ROUTER_STATS_EN
    // 6. statistics and saturation (STAT_W=2)
    do_reset(1);
    for (int i = 0; i < 3; i++) push_flit(2'd1, 32'hD0 + 32'(i));
    push_flit(2'd3, 32'hD3);
    wait_drain();
    repeat (2) step();
    check("t6_cnt0", 64'(stat_cnt0), 64'd0);
    check("t6_cnt1", 64'(stat_cnt1), 64'd3);
    check("t6_cnt2", 64'(stat_cnt2), 64'd0);
    check("t6_cnt3", 64'(stat_cnt3), 64'd1);
    for (int i = 0; i < 5; i++) push_flit(2'd0, 32'hE0 + 32'(i));
    wait_drain();
    repeat (2) step();
    check("t6_cnt0_sat", 64'(stat_cnt0), 64'd3);
    check("t6_cnt1_keep", 64'(stat_cnt1), 64'd3);
`endif

    repeat (2) step();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule

// File: doc/router_ingress_fifo.md
Name: router_ingress_fifo

Overview:
Ingress buffer directly upstream of the 4-way combinational simple_router. Accepts (addr, data) flits on a valid/ready handshake and queues them in a DEPTH-entry FIFO. Issues at most one flit per cycle as a registered one-cycle din_en pulse with addr/din, which feed the router's din_en/addr/din inputs.
- Downstream may pause issue with out_hold.

Parameters:
DATA_SIZE, 32, flit payload width; must match the router's DATA_SIZE.
DEPTH, 4, FIFO entries; power of 2, >= 2.
STAT_W, 16, width of per-destination statistics counters (optional feature only).

Ports:
clk  input  1  clock; all state updates on the rising edge.
resetn  input  1  synchronous active-low reset, sampled on the rising edge of clk.
in_valid  input  1  upstream flit valid.
in_ready  output  1  FIFO can accept; equals !full.
in_addr  input  2  destination port 0..3.
in_data  input  DATA_SIZE  flit payload.
out_hold  input  1  downstream pause; no issue on the next edge while high.
din_en  output  1  registered issue strobe to the router.
addr  output  2  registered destination to the router.
din  output  DATA_SIZE  registered payload to the router.
level  output  $clog2(DEPTH+1)  current FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (resetn=0 at an edge): FIFO emptied (wr_ptr=rd_ptr=0, level=0), din_en=0, addr=0, din=0, in_ready=1 from the next cycle. Reset mid-traffic discards queued flits and any flit presented that cycle.
- Push: in_valid && in_ready at an edge writes {in_addr,in_data} at wr_ptr and advances wr_ptr (wraps at DEPTH).
- in_ready = (level != DEPTH), combinational from level only. When full there is no same-cycle bypass even if a pop occurs.
- Pop/issue: at each edge, if level != 0 and out_hold == 0:
  - the head is loaded into addr/din, din_en <= 1, and rd_ptr advances.
  - Otherwise din_en <= 0, addr <= 0, din <= 0. Idle outputs are zero so the router outputs stay zero.
- din_en is high for exactly one cycle per flit. Back-to-back flits give consecutive din_en cycles.
- Latency: a flit accepted into an empty FIFO at edge k appears on din_en/addr/din after edge k+1 when out_hold=0.
- A flit is never issued in the same edge it is pushed.
- Simultaneous push and pop: level unchanged. Push only: level+1. Pop only: level-1.
- Order: strict FIFO, no reordering by destination.
- out_hold high: the FIFO holds and the output registers clear to 0. Issue resumes at the first edge with out_hold=0.
- in_valid while !in_ready: the flit is not taken; upstream must hold it. Payload values while in_valid=0 are ignored.

Optional Feature:
Macro ROUTER_STATS_EN.
- Defined:
  - Adds outputs stat_cnt0..stat_cnt3, each STAT_W bits.
  - stat_cntN increments after each edge where the registered din_en=1 and addr=N.
  - Counters saturate at all-ones (no wrap) and reset to 0 with resetn.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package router_pkg contains:
  - localparam NUM_PORTS=4 and ADDR_W=2.
  - typedef router_flit_t: packed struct {logic [ADDR_W-1:0] addr; logic [DATA_SIZE-1:0] data;}, parameterised via DATA_SIZE in the package with default 32.
- One natural sub-module: router_sync_fifo. It is a generic DEPTH x width storage with push/pop, full/empty and level, using the same clk/resetn.
- router_ingress_fifo adds the issue register, hold logic and optional stats.

Test Plan:
1. Reset: after resetn=0 for 2 cycles, check din_en=0, addr=0, din=0, level=0, in_ready=1.
2. Single flit: push addr=2, data=0xDEADBEEF into an empty FIFO at edge k with out_hold=0. Expect din_en=1, addr=2, din=0xDEADBEEF for exactly the cycle after edge k+1, then all outputs 0.
3. Fill to full: out_hold=1, push 5 flits (addr 0..3,0; data 0x10..0x14).
   - After 4 pushes: level=4, in_ready=0, and the 5th flit is held.
   - After out_hold=0: din_en high for 4 consecutive cycles with data 0x10..0x13 in order.
   - The 5th flit (0x14) is accepted after the first pop and then issued.
4. Simultaneous push/pop: at level=2 with continuous in_valid and out_hold=0, level stays 2 each cycle, and issued data order equals push order across pointer wrap (>= 10 flits).
5. Reset mid-traffic: level=3 and din_en=1, assert resetn=0 for one edge. Next cycle din_en=0, level=0, and no stale flit is issued afterwards.
6. ROUTER_STATS_EN: issue 3 flits to addr 1 and 1 flit to addr 3; expect stat_cnt1=3, stat_cnt3=1, others 0. With STAT_W=2, 5 flits to addr 0 saturate stat_cnt0 at 3.
